// File: rtl/xup_serial_to_vector_pair.sv
// Serial-to-parallel assembler: collects two SIZE-bit operands LSB-first from a
// valid/ready bit stream and presents them as a registered pair until consumed.
module xup_serial_to_vector_pair #(
    parameter int SIZE  = 8,
    parameter int DELAY = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sin,
    input  logic            sin_valid,
    output logic            sin_ready,
    output logic [SIZE-1:0] a,
    output logic [SIZE-1:0] b,
    output logic            vec_valid,
    input  logic            vec_ready,
    output logic            busy
);
    localparam int CW = $clog2(SIZE);

    // DELAY only shapes output timing in behavioural models; here it is just range-checked.
    if (SIZE < 2 || SIZE > 32 || DELAY < 0) begin : g_bad_param
        $error("xup_serial_to_vector_pair: SIZE must be 2..32 and DELAY >= 0");
    end

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] sa_q, sa_d;
    logic [SIZE-1:0] sb_q, sb_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic            beat;
    logic            last_bit;

    assign sin_ready = (state_q != HOLD);
    assign beat      = sin_valid && sin_ready;
    assign last_bit  = (cnt_q == CW'(SIZE - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        b_d     = b_q;
        if (beat) begin
            cnt_d = last_bit ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            LOAD_A: begin
                if (beat) begin
                    sa_d = {sin, sa_q[SIZE-1:1]};
                    if (last_bit) state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (beat) begin
                    sb_d = {sin, sb_q[SIZE-1:1]};
                    if (last_bit) begin
                        // The final bit goes straight into b, not via sb.
                        a_d     = sa_q;
                        b_d     = {sin, sb_q[SIZE-1:1]};
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (vec_ready) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign vec_valid = (state_q == HOLD);
    assign busy      = ((state_q == LOAD_A) && (cnt_q != '0)) || (state_q == LOAD_B);

endmodule

// File: tb/tb_xup_serial_to_vector_pair.sv
// Directed bench for xup_serial_to_vector_pair (SIZE=8): a vector table for the
// basic pair/hold/consume flow plus hand sequences for gaps, resets and back-to-back.
module tb_xup_serial_to_vector_pair;
    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            reset, sin, sin_valid, vec_ready;
    logic            sin_ready, vec_valid, busy;
    logic [SIZE-1:0] a, b;

    xup_serial_to_vector_pair #(.SIZE(SIZE), .DELAY(3)) dut (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
        .sin_ready(sin_ready), .a(a), .b(b), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, s, sv, vr;
        logic [7:0] ea, eb;
        logic       evv, erdy, ebusy;
    } vec_t;

    vec_t vecs[29];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs, cross one rising edge, then sample well after the output delay.
    task automatic drive(input logic rst, input logic s, input logic sv, input logic vr);
        reset = rst; sin = s; sin_valid = sv; vec_ready = vr;
        @(posedge clk);
        #5;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic evv, input logic erdy, input logic ebusy);
        chk({tag, ".a"}, 32'(a), 32'(ea));
        chk({tag, ".b"}, 32'(b), 32'(eb));
        chk({tag, ".vec_valid"}, 32'(vec_valid), 32'(evv));
        chk({tag, ".sin_ready"}, 32'(sin_ready), 32'(erdy));
        chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    endtask

    // Sends 16 beats (pa then pb, LSB-first) with optional random gaps; checks busy
    // along the way and the pair presented on the cycle after the last beat.
    task automatic send_pair(input string tag, input logic [7:0] pa, input logic [7:0] pb,
                             input bit gaps, input logic vr);
        logic [15:0] stream;
        stream = {pb, pa};
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    drive(1'b0, 1'b0, 1'b0, vr);
                    if (i > 0) chk($sformatf("%s.gap_busy%0d", tag, i), 32'(busy), 32'd1);
                end
            end
            drive(1'b0, stream[i], 1'b1, vr);
            if (i < 15) chk($sformatf("%s.busy%0d", tag, i + 1), 32'(busy), 32'd1);
        end
        chk_out({tag, ".done"}, pa, pb, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] s0;
        s0 = {8'h3C, 8'hA5};

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        for (int k = 1; k <= 16; k++) begin
            vecs[k] = '{1'b0, s0[k-1], 1'b1, 1'b0,
                        (k == 16) ? 8'hA5 : 8'h00, (k == 16) ? 8'h3C : 8'h00,
                        k == 16, k != 16, k < 16};
        end
        for (int k = 17; k <= 26; k++)
            vecs[k] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[28] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; vec_ready = 1'b0;

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].rst, vecs[i].s, vecs[i].sv, vecs[i].vr);
            chk_out($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb,
                    vecs[i].evv, vecs[i].erdy, vecs[i].ebusy);
        end

        // Same pair with random gaps between beats.
        send_pair("gaps", 8'hA5, 8'h3C, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("gaps.consume", 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0);

        // Reset part-way through a pair.
        for (int i = 0; i < 11; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid.busy_before_rst", 32'(busy), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk_out("mid.rst", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        send_pair("fresh", 8'hFF, 8'h01, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back pairs, consumer always ready.
        send_pair("b2b0", 8'h0F, 8'hF0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk_out("b2b0.gone", 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b0);
        send_pair("b2b1", 8'h81, 8'h18, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("b2b1.gone", 8'h81, 8'h18, 1'b0, 1'b1, 1'b0);

        // Reset coincides with the final beat: no pair may appear.
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk_out("rst16", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("rst16.after", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
